// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core: captures the decoded bundle,
// detects load-use hazards, inserts NOOP bubbles on hazard or flush, and counts events.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_d,
  input  logic [15:0]   muxctrl_d,
  input  logic [2:0]    memctrl_d,
  input  logic [4:0]    aluctrl_d,
  input  logic [4:0]    rs_d,
  input  logic [4:0]    rt_d,
  input  logic [4:0]    rd_d,
  input  logic [4:0]    shamt_d,
  input  logic [DW-1:0] reg1_d,
  input  logic [DW-1:0] reg2_d,
  input  logic [DW-1:0] imm_d,
  input  logic [DW-1:0] pc4_d,
  input  logic          flush,
  input  logic          ex_stall,
  output logic          valid_e,
  output logic [15:0]   muxctrl_e,
  output logic [2:0]    memctrl_e,
  output logic [4:0]    aluctrl_e,
  output logic [4:0]    rs_e,
  output logic [4:0]    rt_e,
  output logic [4:0]    shamt_e,
  output logic [DW-1:0] reg1_e,
  output logic [DW-1:0] reg2_e,
  output logic [DW-1:0] imm_e,
  output logic [DW-1:0] pc4_e,
  output logic [4:0]    dest_e,
  output logic          stall_id,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] flush_cnt
);

  localparam logic [4:0] NOOP_ALU = 5'b01101;

  typedef struct packed {
    logic          valid;
    logic [15:0]   muxctrl;
    logic [2:0]    memctrl;
    logic [4:0]    aluctrl;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    shamt;
    logic [DW-1:0] reg1;
    logic [DW-1:0] reg2;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc4;
    logic [4:0]    dest;
  } bundle_t;

  bundle_t       bundle_reg, bundle_next, capture, bubble;
  logic [CW-1:0] stall_cnt_reg, stall_cnt_next;
  logic [CW-1:0] flush_cnt_reg, flush_cnt_next;
  logic [4:0]    dest_d;
  logic          uses_rs, uses_rt, hazard;

  // JAL links to r31; I/J formats write rt; R-type writes rd.
  always_comb begin
    if (muxctrl_d[10])
      dest_d = 5'd31;
    else if (muxctrl_d[1:0] != 2'b00)
      dest_d = rt_d;
    else
      dest_d = rd_d;
  end

  assign uses_rs = ~muxctrl_d[6] & ~(muxctrl_d[7] & muxctrl_d[1]);
  assign uses_rt = ((muxctrl_d[1:0] == 2'b00) & ~muxctrl_d[7]) | muxctrl_d[9] | memctrl_d[1];

  assign hazard = valid_d & bundle_reg.valid & bundle_reg.memctrl[2] & (bundle_reg.dest != 5'd0)
                & ((uses_rs & (rs_d == bundle_reg.dest)) | (uses_rt & (rt_d == bundle_reg.dest)));

  // A flush kills the dependent instruction, so the front end must not be held for it.
  assign stall_id = ex_stall | (hazard & ~flush);

  always_comb begin
    bubble         = '0;
    bubble.aluctrl = NOOP_ALU;

    capture.valid   = valid_d;
    capture.muxctrl = muxctrl_d;
    capture.memctrl = memctrl_d;
    capture.aluctrl = aluctrl_d;
    capture.rs      = rs_d;
    capture.rt      = rt_d;
    capture.shamt   = shamt_d;
    capture.reg1    = reg1_d;
    capture.reg2    = reg2_d;
    capture.imm     = imm_d;
    capture.pc4     = pc4_d;
    capture.dest    = dest_d;

    bundle_next    = bundle_reg;
    stall_cnt_next = stall_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    if (ex_stall) begin
      bundle_next = bundle_reg;
    end else if (flush) begin
      bundle_next = bubble;
      if (flush_cnt_reg != '1)
        flush_cnt_next = flush_cnt_reg + CW'(1);
    end else if (hazard) begin
      bundle_next = bubble;
      if (stall_cnt_reg != '1)
        stall_cnt_next = stall_cnt_reg + CW'(1);
    end else begin
      bundle_next = capture;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bundle_reg    <= bubble;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      bundle_reg    <= bundle_next;
      stall_cnt_reg <= stall_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  assign valid_e   = bundle_reg.valid;
  assign muxctrl_e = bundle_reg.muxctrl;
  assign memctrl_e = bundle_reg.memctrl;
  assign aluctrl_e = bundle_reg.aluctrl;
  assign rs_e      = bundle_reg.rs;
  assign rt_e      = bundle_reg.rt;
  assign shamt_e   = bundle_reg.shamt;
  assign reg1_e    = bundle_reg.reg1;
  assign reg2_e    = bundle_reg.reg2;
  assign imm_e     = bundle_reg.imm;
  assign pc4_e     = bundle_reg.pc4;
  assign dest_e    = bundle_reg.dest;
  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver predicts each edge's outcome from an
// instruction-level model and queues it; a monitor compares the registered outputs.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, valid_d, flush, ex_stall;
  logic [15:0]   muxctrl_d;
  logic [2:0]    memctrl_d;
  logic [4:0]    aluctrl_d, rs_d, rt_d, rd_d, shamt_d;
  logic [DW-1:0] reg1_d, reg2_d, imm_d, pc4_d;
  logic          valid_e, stall_id;
  logic [15:0]   muxctrl_e;
  logic [2:0]    memctrl_e;
  logic [4:0]    aluctrl_e, rs_e, rt_e, shamt_e, dest_e;
  logic [DW-1:0] reg1_e, reg2_e, imm_e, pc4_e;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .valid_d(valid_d), .muxctrl_d(muxctrl_d),
    .memctrl_d(memctrl_d), .aluctrl_d(aluctrl_d), .rs_d(rs_d), .rt_d(rt_d),
    .rd_d(rd_d), .shamt_d(shamt_d), .reg1_d(reg1_d), .reg2_d(reg2_d),
    .imm_d(imm_d), .pc4_d(pc4_d), .flush(flush), .ex_stall(ex_stall),
    .valid_e(valid_e), .muxctrl_e(muxctrl_e), .memctrl_e(memctrl_e),
    .aluctrl_e(aluctrl_e), .rs_e(rs_e), .rt_e(rt_e), .shamt_e(shamt_e),
    .reg1_e(reg1_e), .reg2_e(reg2_e), .imm_e(imm_e), .pc4_e(pc4_e),
    .dest_e(dest_e), .stall_id(stall_id), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic          v;
    logic [15:0]   mux;
    logic [2:0]    mem;
    logic [4:0]    alu, rs, rt, shamt, dest;
    logic [DW-1:0] r1, r2, imm, pc4;
    logic [CW-1:0] sc, fc;
  } snap_t;

  typedef struct {
    logic          v;
    logic [15:0]   mux;
    logic [2:0]    mem;
    logic [4:0]    alu, rs, rt, rd, shamt;
    logic [DW-1:0] r1, r2, imm, pc4;
  } instr_t;

  typedef enum int {K_RTYPE, K_LW, K_SW, K_BR, K_SHIFT, K_J, K_JAL, K_RAND} kind_t;

  snap_t  model;
  snap_t  exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     txn = 0;
  logic   last_stall;

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] x);
    return (x == {CW{1'b1}}) ? x : x + CW'(1);
  endfunction

  function automatic logic [4:0] writes_to(input instr_t i);
    if (i.mux[10]) return 5'd31;
    if (i.mux[1:0] != 2'b00) return i.rt;
    return i.rd;
  endfunction

  // Does the instruction read architectural register r in decode?
  function automatic bit reads(input instr_t i, input logic [4:0] r);
    bit rs_read, rt_read;
    rs_read = !i.mux[6] && !(i.mux[7] && i.mux[1]);
    rt_read = (i.mux[1:0] == 2'b00 && !i.mux[7]) || i.mux[9] || i.mem[1];
    return (rs_read && i.rs == r) || (rt_read && i.rt == r);
  endfunction

  function automatic bit load_use(input instr_t i);
    return i.v && model.v && model.mem[2] && model.dest != 5'd0 && reads(i, model.dest);
  endfunction

  function automatic instr_t mk_instr(input kind_t k, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd);
    instr_t i;
    i.v     = 1'b1;
    i.mux   = 16'($urandom()) & 16'hF93C;
    i.mem   = 3'b001;
    i.alu   = 5'($urandom());
    i.rs    = rs;
    i.rt    = rt;
    i.rd    = rd;
    i.shamt = 5'($urandom());
    i.r1    = $urandom();
    i.r2    = $urandom();
    i.imm   = $urandom();
    i.pc4   = $urandom();
    case (k)
      K_LW:    begin i.mux[0] = 1'b1; i.mem = 3'b101; end
      K_SW:    begin i.mux[0] = 1'b1; i.mem = 3'b010; end
      K_BR:    begin i.mux[9] = 1'b1; i.mux[0] = 1'b1; i.mem = 3'b000; end
      K_SHIFT: i.mux[6] = 1'b1;
      K_J:     begin i.mux[7] = 1'b1; i.mux[1] = 1'b1; i.mem = 3'b000; end
      K_JAL:   begin i.mux[10] = 1'b1; i.mux[7] = 1'b1; i.mux[1] = 1'b1; end
      K_RAND:  begin i.mux = 16'($urandom()); i.mem = 3'($urandom()); end
      default: ;
    endcase
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i = mk_instr(kind_t'($urandom_range(0, 7)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    i.v = ($urandom_range(0, 9) != 0);
    return i;
  endfunction

  function automatic instr_t idle_instr();
    instr_t i;
    i = mk_instr(K_RTYPE, 5'd0, 5'd0, 5'd0);
    i.v = 1'b0;
    return i;
  endfunction

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One decode cycle: drive, check stall_id, predict the edge, queue the prediction.
  task automatic step(input instr_t i, input bit rst, input bit fl, input bit xs);
    bit hz, exp_stall;
    @(negedge clk);
    reset = rst; flush = fl; ex_stall = xs;
    valid_d = i.v; muxctrl_d = i.mux; memctrl_d = i.mem; aluctrl_d = i.alu;
    rs_d = i.rs; rt_d = i.rt; rd_d = i.rd; shamt_d = i.shamt;
    reg1_d = i.r1; reg2_d = i.r2; imm_d = i.imm; pc4_d = i.pc4;
    #1;
    hz = load_use(i);
    exp_stall = xs || (hz && !fl);
    last_stall = exp_stall;
    checks++;
    if (stall_id !== exp_stall) begin
      errors++;
      $display("FAIL stall_id at %0t: got %b expected %b", $time, stall_id, exp_stall);
    end
    if (rst || fl || (!xs && hz)) begin
      snap_t b;
      b = '0;
      b.alu = 5'b01101;
      b.sc = rst ? '0 : model.sc;
      b.fc = rst ? '0 : (xs ? model.fc : model.fc);
      if (!rst && !xs && fl) b.fc = sat(model.fc);
      else if (!rst && !xs && hz) b.sc = sat(model.sc);
      if (rst || !xs) model = b;
    end else if (!xs) begin
      model.v = i.v; model.mux = i.mux; model.mem = i.mem; model.alu = i.alu;
      model.rs = i.rs; model.rt = i.rt; model.shamt = i.shamt; model.dest = writes_to(i);
      model.r1 = i.r1; model.r2 = i.r2; model.imm = i.imm; model.pc4 = i.pc4;
    end
    exp_q.push_back(model);
  endtask

  // Monitor: the stage presents a new registered state after every edge.
  initial begin
    snap_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {valid_e, muxctrl_e, memctrl_e, aluctrl_e, rs_e, rt_e, shamt_e, dest_e,
             reg1_e, reg2_e, imm_e, pc4_e, stall_cnt, flush_cnt};
        checks++;
        txn++;
        if (a !== e) begin
          errors++;
          $display("FAIL ex_regs txn %0d: got %h expected %h", txn, a, e);
        end else begin
          $display("txn %0d ok: v=%0b dest=%0d alu=%b mem=%b sc=%0d fc=%0d",
                   txn, valid_e, dest_e, aluctrl_e, memctrl_e, stall_cnt, flush_cnt);
        end
      end
    end
  end

  initial begin
    instr_t add_i, lw_i, cur;
    model = '0;
    model.alu = 5'b01101;
    last_stall = 1'b0;
    reset = 1'b1; flush = 1'b0; ex_stall = 1'b0;

    // reset for two cycles, then an idle cycle
    step(idle_instr(), 1'b1, 1'b0, 1'b0);
    step(idle_instr(), 1'b1, 1'b0, 1'b0);
    step(idle_instr(), 1'b0, 1'b0, 1'b0);

    // plain ADD capture
    add_i = mk_instr(K_RTYPE, 5'd1, 5'd2, 5'd3);
    add_i.mux = 16'h0000; add_i.alu = 5'b00010;
    step(add_i, 1'b0, 1'b0, 1'b0);

    // load-use: LW r5 then ADD reading r5, held one cycle by the front end
    lw_i = mk_instr(K_LW, 5'd0, 5'd5, 5'd0);
    add_i = mk_instr(K_RTYPE, 5'd5, 5'd2, 5'd6);
    step(lw_i, 1'b0, 1'b0, 1'b0);
    step(add_i, 1'b0, 1'b0, 1'b0);
    step(add_i, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    check_val("stall_cnt_after_load_use", int'(stall_cnt), 1);

    // load into r0 never stalls
    step(mk_instr(K_LW, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0);
    step(mk_instr(K_RTYPE, 5'd0, 5'd0, 5'd4), 1'b0, 1'b0, 1'b0);

    // flush with a simultaneous load-use hazard
    step(lw_i, 1'b0, 1'b0, 1'b0);
    step(add_i, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #2;
    check_val("flush_cnt_after_flush", int'(flush_cnt), 1);
    check_val("stall_cnt_after_flush", int'(stall_cnt), 1);

    // hold for three cycles with changing inputs, including flush/hazard attempts
    step(lw_i, 1'b0, 1'b0, 1'b0);
    step(add_i, 1'b0, 1'b0, 1'b1);
    step(add_i, 1'b0, 1'b1, 1'b1);
    step(rand_instr(), 1'b0, 1'b0, 1'b1);
    step(add_i, 1'b0, 1'b0, 1'b0);
    step(add_i, 1'b0, 1'b0, 1'b0);

    // reset in the middle of a stall
    step(lw_i, 1'b0, 1'b0, 1'b0);
    step(add_i, 1'b1, 1'b0, 1'b1);

    // counter saturation: 18 load-use events on a 4-bit counter
    for (int n = 0; n < 18; n++) begin
      step(mk_instr(K_LW, 5'd1, 5'd7, 5'd0), 1'b0, 1'b0, 1'b0);
      step(mk_instr(K_RTYPE, 5'd7, 5'd2, 5'd3), 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk); #2;
    check_val("stall_cnt_saturated", int'(stall_cnt), 15);

    // randomized traffic; the front end repeats an instruction while stalled
    cur = rand_instr();
    for (int n = 0; n < 300; n++) begin
      bit rst, fl, xs;
      rst = ($urandom_range(0, 59) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      xs  = ($urandom_range(0, 6) == 0);
      step(cur, rst, fl, xs);
      if (!last_stall || rst) cur = rand_instr();
    end

    // drain the scoreboard within a bounded number of cycles
    repeat (3) @(posedge clk);
    #2;
    check_val("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between the decode stage (instruction decoder plus register file) and the execute stage of the 5-stage MIPS core. It captures the decoded control bundle (`muxctrl`, `memctrl`, `aluctrl`), operands and register addresses each cycle. It detects load-use hazards, stalls the front end, and substitutes NOOP bubbles on hazard or branch/jump flush. Saturating counters record stall and flush activity for performance debug.

## Interface
Parameters:
- `DW`, 32, datapath width of operand, immediate and PC fields
- `CW`, 16, width of the stall/flush event counters

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset; one clock, synchronous reset, active-high
- `valid_d`  in  1  decode slot holds a real instruction
- `muxctrl_d`  in  16  decoded mux control bundle
- `memctrl_d`  in  3  decoded memory control: bit0 reg write, bit1 mem write, bit2 mem read
- `aluctrl_d`  in  5  decoded ALU operation
- `rs_d`, `rt_d`, `rd_d`  in  5 each  register addresses from the instruction
- `shamt_d`  in  5  shift amount
- `reg1_d`, `reg2_d`, `imm_d`, `pc4_d`  in  DW each  register read data, extended immediate, PC+4
- `flush`  in  1  taken branch/jump resolved in EX; kill the decode-slot instruction
- `ex_stall`  in  1  downstream busy; hold this register
- `valid_e`, `muxctrl_e`, `memctrl_e`, `aluctrl_e`, `rs_e`, `rt_e`, `shamt_e`, `reg1_e`, `reg2_e`, `imm_e`, `pc4_e`  out  registered copies of the matching `_d` inputs
- `dest_e`  out  5  resolved write-back register
- `stall_id`  out  1  hold the PC and the IF/ID register this cycle (combinational)
- `stall_cnt`, `flush_cnt`  out  CW each  saturating event counters

## Operation
- Destination resolution at capture: `muxctrl_d[10]` (JAL) gives 31. Else `muxctrl_d[1:0]!=0` (I/J-type) gives `rt_d`. Else `rd_d`.
- Source usage in decode:
  - `uses_rs` = NOT `muxctrl_d[6]` (shift-immediate) AND NOT (`muxctrl_d[7]` AND `muxctrl_d[1]`) (J/JAL).
  - `uses_rt` = (`muxctrl_d[1:0]==00` AND NOT `muxctrl_d[7]`) OR `muxctrl_d[9]` (branch) OR `memctrl_d[1]` (store).
- `hazard` = `valid_d` & `valid_e` & `memctrl_e[2]` & (`dest_e!=0`) & ((`uses_rs` & `rs_d==dest_e`) | (`uses_rt` & `rt_d==dest_e`)).
- `stall_id` = `ex_stall` | (`hazard` & !`flush`).
- Per-edge priority, highest first:
  1. `reset`: load a bubble; clear both counters.
  2. `ex_stall`: hold all registers; counters unchanged.
  3. `flush`: load a bubble; `flush_cnt`+1.
  4. `hazard`: load a bubble; `stall_cnt`+1.
  5. Otherwise: capture all `_d` fields; `valid_e`=`valid_d`.
- Bubble contents: `valid_e`=0, `muxctrl_e`=0, `memctrl_e`=000, `aluctrl_e`=01101, every other output field 0.
- A bubble must never write a register or memory.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset values: bubble contents as above; `stall_cnt`=`flush_cnt`=0; `stall_id` = `ex_stall` (the hazard term is 0 because `valid_e`=0).
- Capture latency: one cycle, decode inputs at edge N appear on the outputs after edge N.
- A load-use hazard stalls exactly one cycle. After the bubble, `valid_e`=0, so `hazard` drops. The held instruction is captured on the next edge.
- Flush and hazard in the same cycle: flush wins. `stall_id` stays 0 so the front end advances; only `flush_cnt` increments.
- Flush or hazard while `ex_stall` is high: no effect. Hazard is re-evaluated after `ex_stall` drops.
- Reset during a stall: bubble on the next edge; the stall ends.
- `valid_d`=0 never raises `hazard`.

## Test plan
- Reset: assert `reset` for 2 cycles, then deassert -> `valid_e`=0, `aluctrl_e`=01101, `memctrl_e`=000, both counters 0, `stall_id`=0.
- ADD capture: `rs`=1, `rt`=2, `rd`=3, `memctrl`=001, `aluctrl`=00010 -> next cycle `dest_e`=3, `valid_e`=1, all fields match the inputs.
- Load-use: LW `rt`=5, then ADD `rs`=5 -> `stall_id`=1 for exactly one cycle; one bubble inserted; ADD captured one cycle later; `stall_cnt`=1.
- LW into register 0 followed by a use of register 0 -> `stall_id` stays 0; `stall_cnt`=0.
- Flush with a simultaneous load-use hazard -> bubble loaded, `stall_id`=0, `flush_cnt`=1, `stall_cnt`=0.
- Hold: `ex_stall` for 3 cycles with changing inputs -> all outputs constant and `stall_id`=1 throughout.
- Saturation: force 2^CW+2 hazard events with CW=4 -> `stall_cnt` holds at 0xF.
